// File: rtl/disp_pkg.sv
// Shared types and AXI constants for the display VRAM fetch path.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } disp_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE      = 4'b0011;

    function automatic logic [2:0] arsize(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

    function automatic int burst_bytes(input int burst_len, input int data_w);
        return burst_len * data_w / 8;
    endfunction

endpackage

// File: rtl/disp_fetch_addrgen.sv
// Burst/line address walker: steps ARADDR by one burst per accepted AR and
// jumps to the next line start (line_base + stride) at the end of each line.
module disp_fetch_addrgen
    import disp_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 8,
    parameter int HPIX_W    = 12,
    parameter int VLINE_W   = 11
) (
    input  logic               ACLK,
    input  logic               ARST,
    input  logic               load,
    input  logic               step,
    input  logic [ADDR_W-1:0]  base,
    input  logic [HPIX_W-1:0]  hpixels,
    input  logic [VLINE_W-1:0] vlines,
    input  logic [15:0]        stride,
    output logic [ADDR_W-1:0]  araddr,
    output logic               last_in_line,
    output logic               last_in_frame
);

    localparam int BB      = burst_bytes(BURST_LEN, DATA_W);
    localparam int BB_LOG2 = $clog2(BB);
    localparam int CNT_W   = HPIX_W + 2;

    logic [CNT_W-1:0]   burst_cnt;
    logic [CNT_W-1:0]   bpl_m1;
    logic [VLINE_W-1:0] line_cnt;
    logic [VLINE_W-1:0] vlines_m1;
    logic [ADDR_W-1:0]  line_base;
    logic [ADDR_W-1:0]  stride_q;
    logic [CNT_W-1:0]   line_bytes;
    logic [ADDR_W-1:0]  next_line_base;

    // Pixels are 4 bytes; the line length is a whole number of bursts.
    assign line_bytes     = {hpixels, 2'b00};
    assign next_line_base = line_base + stride_q;
    assign last_in_line   = (burst_cnt == bpl_m1);
    assign last_in_frame  = last_in_line && (line_cnt == vlines_m1);

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            burst_cnt <= '0;
            bpl_m1    <= '0;
            line_cnt  <= '0;
            vlines_m1 <= '0;
            line_base <= '0;
            stride_q  <= '0;
            araddr    <= '0;
        end else if (load) begin
            burst_cnt <= '0;
            bpl_m1    <= (line_bytes >> BB_LOG2) - CNT_W'(1);
            line_cnt  <= '0;
            vlines_m1 <= vlines - VLINE_W'(1);
            line_base <= base;
            stride_q  <= ADDR_W'(stride);
            araddr    <= base;
        end else if (step) begin
            if (last_in_line) begin
                burst_cnt <= '0;
                line_cnt  <= line_cnt + VLINE_W'(1);
                line_base <= next_line_base;
                araddr    <= next_line_base;
            end else begin
                burst_cnt <= burst_cnt + CNT_W'(1);
                araddr    <= araddr + ADDR_W'(BB);
            end
        end
    end

endmodule

// File: rtl/disp_vramfetch.sv
// AXI4 read-address master fetching one display frame from VRAM per START.
// Optional RRESP checking is enabled with `define DISP_FETCH_RRESP_CHK_EN.
//
// Handshakes: AR is valid/ready; once ARVALID is raised it and ARADDR hold
// until ARREADY. R is accepted unconditionally (RREADY=1 out of reset); flow
// control toward the line buffer happens only on AR issue.
module disp_vramfetch
    import disp_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 8,
    parameter int MAX_OUTST = 4,
    parameter int HPIX_W    = 12,
    parameter int VLINE_W   = 11
) (
    input  logic               ACLK,
    input  logic               ARST,
    input  logic               START,
    input  logic               DISPON,
    input  logic [ADDR_W-1:0]  BASEADDR,
    input  logic [HPIX_W-1:0]  HPIXELS,
    input  logic [VLINE_W-1:0] VLINES,
    input  logic [15:0]        STRIDE,
    input  logic               BUF_WREADY,
    output logic [ADDR_W-1:0]  ARADDR,
    output logic               ARVALID,
    output logic [7:0]         ARLEN,
    input  logic               ARREADY,
    input  logic               RVALID,
    input  logic               RLAST,
    input  logic [1:0]         RRESP,
    output logic               RREADY,
    output logic               BUSY,
    output logic               FRAME_DONE,
    output logic               RESP_ERR,
    output disp_state_e        FSM_STATE
);

    localparam logic [3:0] MAX_Q = 4'(MAX_OUTST);

    disp_state_e state, state_nxt;
    logic [3:0]  outst, outst_nxt;
    logic        arvalid_nxt;
    logic        aborted, aborted_nxt;
    logic        done_nxt;
    logic        ar_hs, r_last_hs, launch, can_issue;
    logic        last_in_line, last_in_frame;

    assign ARLEN     = 8'(BURST_LEN - 1);
    assign FSM_STATE = state;
    assign ar_hs     = ARVALID & ARREADY;
    // Beats with nothing outstanding (stale data after a reset) are ignored.
    assign r_last_hs = RVALID & RREADY & RLAST & (outst != 4'd0);
    assign launch    = (state == ST_IDLE) & START & DISPON & (VLINES != '0);
    assign can_issue = DISPON & BUF_WREADY & (outst_nxt < MAX_Q);

    always_comb begin
        outst_nxt = outst;
        case ({ar_hs, r_last_hs})
            2'b10:   outst_nxt = outst + 4'd1;
            2'b01:   outst_nxt = outst - 4'd1;
            default: outst_nxt = outst;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        arvalid_nxt = ARVALID;
        aborted_nxt = aborted;
        done_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                arvalid_nxt = 1'b0;
                if (launch) begin
                    state_nxt   = ST_REQ;
                    aborted_nxt = 1'b0;
                end
            end
            ST_REQ: begin
                if (ARVALID && !ARREADY) begin
                    arvalid_nxt = 1'b1;
                end else if (ar_hs && last_in_frame) begin
                    state_nxt   = ST_DRAIN;
                    arvalid_nxt = 1'b0;
                end else if (!DISPON) begin
                    state_nxt   = ST_DRAIN;
                    arvalid_nxt = 1'b0;
                    aborted_nxt = 1'b1;
                end else begin
                    arvalid_nxt = can_issue;
                end
            end
            ST_DRAIN: begin
                arvalid_nxt = 1'b0;
                if (outst == 4'd0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = !aborted;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                arvalid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state      <= ST_IDLE;
            ARVALID    <= 1'b0;
            aborted    <= 1'b0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
            RREADY     <= 1'b0;
            outst      <= 4'd0;
        end else begin
            state      <= state_nxt;
            ARVALID    <= arvalid_nxt;
            aborted    <= aborted_nxt;
            FRAME_DONE <= done_nxt;
            BUSY       <= (state_nxt != ST_IDLE);
            RREADY     <= 1'b1;
            outst      <= outst_nxt;
        end
    end

`ifdef DISP_FETCH_RRESP_CHK_EN
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            RESP_ERR <= 1'b0;
        end else if (launch) begin
            RESP_ERR <= 1'b0;
        end else if (RVALID && RREADY && (RRESP != 2'b00)) begin
            RESP_ERR <= 1'b1;
        end
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^RRESP;
    assign RESP_ERR     = 1'b0;
`endif

    disp_fetch_addrgen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .HPIX_W    (HPIX_W),
        .VLINE_W   (VLINE_W)
    ) u_addrgen (
        .ACLK          (ACLK),
        .ARST          (ARST),
        .load          (launch),
        .step          (ar_hs),
        .base          (BASEADDR),
        .hpixels       (HPIXELS),
        .vlines        (VLINES),
        .stride        (STRIDE),
        .araddr        (ARADDR),
        .last_in_line  (last_in_line),
        .last_in_frame (last_in_frame)
    );

endmodule
